memory_stage: RTL and testbench

- Y86-64 memory stage, directly downstream of execute; consumes icode, valE, valA, valP for one instruction per handshake.
- Performs the 8-byte little-endian data-memory read or write the instruction requires, then produces valM and a status code for write-back.
- Multi-cycle access: latency set by parameter; an FSM and counter sequence each access.

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/memory_stage_if.sv | 26 ++
 rtl/memory_stage_data_memory.sv | 34 +++
 rtl/memory_stage.sv | 145 ++++++++++++++
 tb/tb_memory_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, memory-stage FSM states.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } mem_state_t;

   // Instructions that load 8 bytes from data memory.
   function automatic logic is_read(input logic [3:0] ic);
      return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
   endfunction

   // Instructions that store 8 bytes to data memory.
   function automatic logic is_write(input logic [3:0] ic);
      return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
   endfunction

   // ret/popq address through the stack pointer held in valA; everything else uses valE.
   function automatic logic [63:0] mem_addr_of(input logic [3:0] ic,
                                                input logic [63:0] vale,
                                                input logic [63:0] vala);
      return ((ic == I_RET) || (ic == I_POPQ)) ? vala : vale;
   endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-memory-stage request bundle plus the write-back result bundle.
// Latency: none (wires only).
// Backpressure: upstream holds request fields while busy is high or until done.
interface memory_stage_if;
   logic        in_valid;
   logic [3:0]  icode;
   logic [63:0] valE;
   logic [63:0] valA;
   logic [63:0] valP;
   logic        busy;
   logic        done;
   logic [63:0] valM;
   logic [2:0]  stat;
   logic [3:0]  out_icode;
   logic [63:0] out_valE;

   modport master (
      output in_valid, icode, valE, valA, valP,
      input  busy, done, valM, stat, out_icode, out_valE
   );

   modport slave (
      input  in_valid, icode, valE, valA, valP,
      output busy, done, valM, stat, out_icode, out_valE
   );
endinterface

// File: rtl/memory_stage_data_memory.sv
// Byte-addressed data memory with one 8-byte little-endian read/write port.
// Latency: read is combinational, write commits on the clock edge with we high.
// Backpressure: none; caller guarantees addr <= MEM_BYTES-8.
module data_memory #(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = $clog2(MEM_BYTES)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   input  logic          we,
   output logic [63:0]   rdata
);

   logic [7:0] mem [MEM_BYTES];

   // Little-endian gather: byte at addr lands in rdata[7:0].
   always_comb begin
      rdata = '0;
      for (int i = 0; i < 8; i++) begin
         rdata[8*i +: 8] = mem[addr + AW'(i)];
      end
   end

   // Little-endian scatter; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            mem[addr + AW'(i)] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: performs the instruction's data-memory access, returns valM and stat.
// Latency: MEM_LAT+1 cycles from accept to done for in-bounds memory ops, 1 cycle otherwise.
// Backpressure: in_valid ignored while busy or done; upstream holds inputs until done.
module memory_stage
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int MEM_LAT   = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   memory_stage_if.slave  bus
);

   localparam int          AW       = $clog2(MEM_BYTES);
   localparam int          CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   mem_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [63:0]   valm_q, valm_d;
   logic [2:0]    stat_q, stat_d;
   logic [3:0]    out_icode_q, out_icode_d;
   logic [63:0]   out_vale_q, out_vale_d;
   logic [3:0]    icode_q, icode_d;
   logic [63:0]   vale_q, vale_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [63:0]   wdata_q, wdata_d;

   logic [63:0]   in_addr;
   logic          in_mem_op;
   logic          mem_we;
   logic [63:0]   mem_rdata;

   assign in_addr   = mem_addr_of(bus.icode, bus.valE, bus.valA);
   assign in_mem_op = is_read(bus.icode) || is_write(bus.icode);
   // Stores commit only on the final ACCESS edge, so a reset mid-access leaves memory intact.
   assign mem_we    = (state_q == S_ACCESS) && (cnt_q == '0) && is_write(icode_q);

   data_memory #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_dmem (
      .clk   (clk),
      .addr  (addr_q),
      .wdata (wdata_q),
      .we    (mem_we),
      .rdata (mem_rdata)
   );

   // Next-state, counter and result computation for the IDLE/ACCESS/DONE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      valm_d      = valm_q;
      stat_d      = stat_q;
      out_icode_d = out_icode_q;
      out_vale_d  = out_vale_q;
      icode_d     = icode_q;
      vale_d      = vale_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               icode_d = bus.icode;
               vale_d  = bus.valE;
               addr_d  = in_addr[AW-1:0];
               wdata_d = (bus.icode == I_CALL) ? bus.valP : bus.valA;
               if (in_mem_op && (in_addr <= ADDR_MAX)) begin
                  state_d = S_ACCESS;
                  cnt_d   = CNT_INIT;
                  busy_d  = 1'b1;
               end else begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  valm_d      = '0;
                  out_icode_d = bus.icode;
                  out_vale_d  = bus.valE;
                  if (bus.icode == I_HALT)     stat_d = STAT_HLT;
                  else if (bus.icode > I_POPQ) stat_d = STAT_INS;
                  else if (in_mem_op)          stat_d = STAT_ADR;
                  else                         stat_d = STAT_AOK;
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d     = S_DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               valm_d      = is_read(icode_q) ? mem_rdata : 64'd0;
               stat_d      = STAT_AOK;
               out_icode_d = icode_q;
               out_vale_d  = vale_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valm_q      <= '0;
         stat_q      <= STAT_AOK;
         out_icode_q <= '0;
         out_vale_q  <= '0;
         icode_q     <= '0;
         vale_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         valm_q      <= valm_d;
         stat_q      <= stat_d;
         out_icode_q <= out_icode_d;
         out_vale_q  <= out_vale_d;
         icode_q     <= icode_d;
         vale_q      <= vale_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.valM      = valm_q;
   assign bus.stat      = stat_q;
   assign bus.out_icode = out_icode_q;
   assign bus.out_valE  = out_vale_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a reference model of the memory stage.
// Latency: model predicts done MEM_LAT+1 cycles after accept for in-bounds memory ops, else 1.
// Backpressure: stimulus waits for each completion before issuing the next instruction.
module tb_memory_stage;
   import y86_pkg::*;

   localparam int MB = 1024;
   localparam int ML = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memory_stage_if bus();

   memory_stage #(.MEM_BYTES(MB), .MEM_LAT(ML)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  stat;
      logic [63:0] valm;
      logic [3:0]  ic;
      logic [63:0] vale;
      int          lat;
      int          acc;
   } exp_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t expq[$];
   logic [7:0] mm [longint unsigned];

   always @(posedge clk) cyc++;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Compare every completion against the oldest model prediction.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check64("stat", 64'(bus.stat), 64'(e.stat));
            check64("valM", bus.valM, e.valm);
            check64("out_icode", 64'(bus.out_icode), 64'(e.ic));
            check64("out_valE", bus.out_valE, e.vale);
            check64("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            check64("busy_at_done", 64'(bus.busy), 64'd0);
         end
      end
   end

   // Reference model: expected results and memory effect of one instruction.
   task automatic model(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, output exp_t x);
      logic rd, wr;
      longint unsigned ad;
      logic [63:0] wd;
      rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
      ad = (ic == 4'h9 || ic == 4'hB) ? a : e;
      wd = (ic == 4'h8) ? p : a;
      x.ic = ic;
      x.vale = e;
      x.valm = 64'd0;
      x.lat = 1;
      x.acc = 0;
      if (ic == 4'h0)                  x.stat = 3'd2;
      else if (ic > 4'hB)              x.stat = 3'd4;
      else if (!(rd || wr))            x.stat = 3'd1;
      else if (ad > longint'(MB - 8))  x.stat = 3'd3;
      else begin
         x.stat = 3'd1;
         x.lat = ML + 1;
         if (rd) for (int i = 0; i < 8; i++) x.valm[8*i +: 8] = mm[ad + longint'(i)];
         if (wr) for (int i = 0; i < 8; i++) mm[ad + longint'(i)] = wd[8*i +: 8];
      end
   endtask

   // Issue one instruction, optionally poke a mrmovq during ACCESS, wait for completion.
   task automatic run(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                      input logic [63:0] p, input bit poke);
      exp_t x;
      int k;
      @(posedge clk); #1;
      model(ic, e, a, p, x);
      bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      x.acc = cyc;
      expq.push_back(x);
      if (poke) begin
         check64("busy_in_access", 64'(bus.busy), 64'd1);
         bus.icode = 4'h5; bus.valE = 64'h40; bus.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0; bus.icode = ic; bus.valE = e;
      end
      k = 0;
      while (expq.size() != 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done icode=%h", ic);
         expq.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check64({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check64({tag, "_done"}, 64'(bus.done), 64'd0);
      check64({tag, "_valM"}, bus.valM, 64'd0);
      check64({tag, "_stat"}, 64'(bus.stat), 64'd1);
      check64({tag, "_out_icode"}, 64'(bus.out_icode), 64'd0);
      check64({tag, "_out_valE"}, bus.out_valE, 64'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.icode = '0; bus.valE = '0; bus.valA = '0; bus.valP = '0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;

      // Write then read, including a misaligned read spanning 0x41..0x48.
      run(4'h4, 64'h48, 64'hA5A5A5A5A5A5A5A5, 64'h0, 1'b0);
      run(4'h4, 64'h40, 64'h1122334455667788, 64'h0, 1'b0);
      run(4'h5, 64'h40, 64'h0, 64'h0, 1'b0);
      check64("lit_read40", bus.valM, 64'h1122334455667788);
      check64("lit_read40_stat", 64'(bus.stat), 64'd1);
      run(4'h5, 64'h41, 64'h0, 64'h0, 1'b0);
      check64("lit_read41", bus.valM, 64'hA511223344556677);

      // call / ret / popq through the stack address.
      run(4'h8, 64'h200, 64'h0, 64'h37, 1'b0);
      run(4'h9, 64'h1F8, 64'h200, 64'h0, 1'b0);
      check64("lit_ret", bus.valM, 64'h37);
      run(4'hB, 64'h208, 64'h200, 64'h0, 1'b0);
      check64("lit_popq", bus.valM, 64'h37);

      // Bounds: last legal address, just past it, and a huge address that would wrap.
      run(4'h4, 64'(MB - 8), 64'h0BADF00D0BADF00D, 64'h0, 1'b0);
      run(4'h5, 64'(MB - 7), 64'h0, 64'h0, 1'b0);
      check64("lit_adr_stat", 64'(bus.stat), 64'd3);
      check64("lit_adr_valM", bus.valM, 64'd0);
      run(4'hA, 64'hFFFFFFFFFFFFFFF8, 64'h5555555555555555, 64'h0, 1'b0);
      check64("lit_push_adr_stat", 64'(bus.stat), 64'd3);
      run(4'h5, 64'(MB - 8), 64'h0, 64'h0, 1'b0);
      check64("lit_mem_unchanged", bus.valM, 64'h0BADF00D0BADF00D);

      // Status codes for non-memory instructions.
      run(4'h0, 64'h0, 64'h0, 64'h0, 1'b0);
      check64("lit_hlt", 64'(bus.stat), 64'd2);
      run(4'hC, 64'h0, 64'h0, 64'h0, 1'b0);
      check64("lit_ins", 64'(bus.stat), 64'd4);
      run(4'h6, 64'h5, 64'h9, 64'h0, 1'b0);
      check64("lit_opq_stat", 64'(bus.stat), 64'd1);
      check64("lit_opq_valM", bus.valM, 64'd0);
      check64("lit_opq_valE", bus.out_valE, 64'h5);

      // Request during ACCESS must be ignored.
      run(4'h4, 64'h80, 64'h0102030405060708, 64'h0, 1'b1);
      run(4'h5, 64'h80, 64'h0, 64'h0, 1'b0);

      // Reset mid-ACCESS aborts the store.
      run(4'h4, 64'h100, 64'hCAFEF00DCAFEF00D, 64'h0, 1'b0);
      @(posedge clk); #1;
      bus.icode = 4'h4; bus.valE = 64'h100; bus.valA = 64'hDEADBEEF; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check64("abort_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check64("done_in_reset", 64'(bus.done), 64'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      run(4'h5, 64'h100, 64'h0, 64'h0, 1'b0);
      check64("lit_abort_read", bus.valM, 64'hCAFEF00DCAFEF00D);

      repeat (8) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
